uart_tx_framer: RTL and testbench
=================================

Name: uart_tx_framer

Overview:
- Transmit-side framing stage that sits directly upstream of the UART flow-control block.
- Accepts parallel bytes over a valid/ready handshake and holds one byte in a single-entry holding register.
- Requests the line by driving its active-low RTS into the flow controller, waits for the CTS grant and the TX enable, then serializes each frame on tx_o.
- Frame format: start bit, data LSB-first, optional parity, 1 or 2 stop bits; bit timing comes from an internal baud counter.

Parameters:
- DATA_W, 8, data bits per frame.
- DIV_W, 16, width of the baud divisor input.

Ports:
- tck  in  1  clock; the block uses this single clock only.
- rst  in  1  reset; synchronous, active-high.
- data_i  in  DATA_W  byte to transmit.
- valid_i  in  1  data_i valid.
- ready_o  out  1  holding register empty; a transfer occurs when valid_i & ready_o.
- baud_div_i  in  DIV_W  clocks per bit minus 1.
- parity_en_i  in  1  parity bit enable.
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- stop2_i  in  1  1 = two stop bits.
- tx_rts_n_o  out  1  active-low request to the flow controller.
- tx_cts_n_i  in  1  active-low grant from the flow controller.
- tx_enable_i  in  1  TX direction enabled (half-duplex/simplex gating).
- tx_o  out  1  serial line; idles high.
- busy_o  out  1  frame in progress (states START through STOP).

Behaviour:
- Reset (rst=1 at a tck edge): state=IDLE, tx_o=1, tx_rts_n_o=1, ready_o=1, busy_o=0, holding register empty, baud counter=0. Reset mid-frame aborts the frame; tx_o returns high on the next cycle.
- All outputs are registered.
- Holding register
  - Loads on valid_i & ready_o; ready_o drops the next cycle.
  - Freed in the cycle the shift register loads from it; ready_o rises the following cycle.
  - This lets the next byte be accepted while the current frame is on the line.
- State machine: IDLE, REQ, START, DATA, PARITY, STOP.
  - IDLE: tx_rts_n_o=1. If holding full, go to REQ.
  - REQ: tx_rts_n_o=0. When tx_cts_n_i=0 & tx_enable_i=1 in the same cycle:
    - load shift register from holding;
    - latch parity_en_i, parity_odd_i, stop2_i and baud_div_i (these stay stable for the whole frame);
    - go to START; tx_o=0 from the next cycle.
    - Otherwise wait indefinitely; there is no timeout.
  - START: 1 bit time, tx_o=0, then DATA.
  - DATA: DATA_W bits LSB-first, bit index 0..DATA_W-1. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx_o = XOR(data) ^ parity_odd, 1 bit time.
  - STOP: tx_o=1 for 1 bit time (2 if stop2). At the end:
    - holding full: go directly to REQ with tx_rts_n_o held 0 (no IDLE gap in the request);
    - holding empty: go to IDLE and tx_rts_n_o=1 the next cycle.
- Request during a frame: tx_rts_n_o stays 0 from REQ through the end of STOP.
- Bit time: exactly baud_div_i+1 tck cycles.
  - The counter loads the latched divisor at bit start, decrements, and advances the bit at 0.
  - baud_div_i=0 gives 1 cycle per bit.
- Frame length: (1 + DATA_W + P + S) x (div+1) cycles, where P = parity enable (0/1) and S = 1 or 2 stop bits.
- Grant loss mid-frame: tx_cts_n_i rising or tx_enable_i falling after START does not abort. The frame completes; these inputs are sampled only in REQ.
- Simultaneous events:
  - valid_i arriving in the same cycle the holding register frees is not accepted, because ready_o is still 0. It is accepted one cycle later.
  - valid_i arriving in the last STOP cycle while holding is empty is accepted. The FSM still goes to IDLE, then to REQ the next cycle.
- busy_o=1 in START, DATA, PARITY, STOP; 0 in IDLE and REQ.

Test Plan:
- Reset with defaults: after rst, tx_o=1, tx_rts_n_o=1, ready_o=1, busy_o=0.
- Basic 8N1 frame:
  - stimulus: div=3, no parity, 1 stop; send 0xA5 with cts_n=0, enable=1;
  - required: rts_n falls 1 cycle after accept; tx_o shows 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles; rts_n=1 one cycle after the stop bit ends.
- Parity and two stop bits:
  - 0x03, even parity, stop2=1, div=0: parity bit=0, 12-cycle frame.
  - Same byte with odd parity: parity bit=1.
- Grant wait:
  - stimulus: hold cts_n=1 for 50 cycles after a byte is accepted;
  - required: rts_n=0, tx_o=1 throughout. Then cts_n=0 with enable=0 keeps waiting; enable=1 starts the frame with tx_o=0 on the next cycle.
- Back-to-back:
  - stimulus: send 0x55 then 0xAA immediately;
  - required: second accepted while the first is on the line; rts_n never deasserts; second start bit follows the first stop bit by exactly 1 REQ cycle.
- Mid-frame disruption:
  - stimulus: release cts_n at DATA bit 3;
  - required: frame completes unchanged.
  - Separately, assert rst at DATA bit 3: tx_o=1, rts_n=1, ready_o=1 the next cycle; no residual frame.

Source files
------------

// File: rtl/uart_tx_framer_if.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_framer_if
// Brief    : Byte handshake (data/valid/ready) into the UART TX framer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_tx_framer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              ready_o;

    modport master (output data_i, output valid_i, input  ready_o);
    modport slave  (input  data_i, input  valid_i, output ready_o);
endinterface

`default_nettype wire

// File: rtl/uart_tx_framer.sv
//------------------------------------------------------------------------------
// Module   : uart_tx_framer
// Brief    : Single-entry holding register, RTS/CTS line request and UART
//            frame serializer (start, data LSB-first, parity, 1/2 stop).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_framer #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  wire logic             tck,
    input  wire logic             rst,
    uart_tx_framer_if.slave       s_if,
    input  wire logic [DIV_W-1:0] baud_div_i,
    input  wire logic             parity_en_i,
    input  wire logic             parity_odd_i,
    input  wire logic             stop2_i,
    output logic                  tx_rts_n_o,
    input  wire logic             tx_cts_n_i,
    input  wire logic             tx_enable_i,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int c_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_hold_data;
    logic                r_hold_full;
    logic                r_ready;
    logic [DATA_W-1:0]   r_shift;
    logic [c_IDX_W-1:0]  r_bit_idx;
    logic                r_stop_idx;
    logic [DIV_W-1:0]    r_div;
    logic [DIV_W-1:0]    r_baud_cnt;
    logic                r_par_en;
    logic                r_parity;
    logic                r_stop2;
    logic                r_tx;
    logic                r_rts_n;
    logic                r_busy;

    logic w_accept;
    logic w_load;
    logic w_bit_end;

    assign w_accept  = s_if.valid_i & r_ready;
    // Grant is only looked at while requesting; later CTS/enable changes never abort a frame.
    assign w_load    = (r_state == ST_REQ) & ~tx_cts_n_i & tx_enable_i;
    assign w_bit_end = (r_baud_cnt == '0);

    assign s_if.ready_o = r_ready;
    assign tx_o         = r_tx;
    assign tx_rts_n_o   = r_rts_n;
    assign busy_o       = r_busy;

    always_ff @(posedge tck) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold_data <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_div       <= '0;
            r_baud_cnt  <= '0;
            r_par_en    <= 1'b0;
            r_parity    <= 1'b0;
            r_stop2     <= 1'b0;
            r_tx        <= 1'b1;
            r_rts_n     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_data <= s_if.data_i;
                r_hold_full <= 1'b1;
                r_ready     <= 1'b0;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
                r_ready     <= 1'b1;
            end

            if (r_busy && !w_bit_end) begin
                r_baud_cnt <= r_baud_cnt - DIV_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_hold_full) begin
                        r_state <= ST_REQ;
                        r_rts_n <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (w_load) begin
                        r_shift    <= r_hold_data;
                        r_parity   <= (^r_hold_data) ^ parity_odd_i;
                        r_par_en   <= parity_en_i;
                        r_stop2    <= stop2_i;
                        r_div      <= baud_div_i;
                        r_baud_cnt <= baud_div_i;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx       <= r_shift[0];
                        r_baud_cnt <= r_div;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_div;
                        if (r_bit_idx == c_LAST_IDX) begin
                            if (r_par_en) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + c_IDX_W'(1);
                            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= r_div;
                        r_tx       <= 1'b1;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop2 && !r_stop_idx) begin
                            r_stop_idx <= 1'b1;
                            r_baud_cnt <= r_div;
                        end else begin
                            // A byte already waiting keeps RTS asserted straight into the next request.
                            r_busy <= 1'b0;
                            if (r_hold_full) begin
                                r_state <= ST_REQ;
                            end else begin
                                r_state <= ST_IDLE;
                                r_rts_n <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_rts_n <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
//------------------------------------------------------------------------------
// Module   : tb_uart_tx_framer
// Brief    : Directed self-checking bench for uart_tx_framer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_framer;

    logic        tck = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        cts_n;
    logic        tx_en;
    logic        rts_n;
    logic        tx;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    uart_tx_framer_if #(.DATA_W(8)) u_if ();

    uart_tx_framer #(
        .DATA_W (8),
        .DIV_W  (16)
    ) u_dut (
        .tck          (tck),
        .rst          (rst),
        .s_if         (u_if),
        .baud_div_i   (baud_div),
        .parity_en_i  (parity_en),
        .parity_odd_i (parity_odd),
        .stop2_i      (stop2),
        .tx_rts_n_o   (rts_n),
        .tx_cts_n_i   (cts_n),
        .tx_enable_i  (tx_en),
        .tx_o         (tx),
        .busy_o       (busy)
    );

    always #5 tck = ~tck;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    // Present a byte, wait (bounded) for ready, and return just after the accepting edge.
    task automatic send_byte(input logic [7:0] d);
        int w;
        u_if.data_i  = d;
        u_if.valid_i = 1'b1;
        w = 0;
        while (u_if.ready_o !== 1'b1 && w < 200) begin
            tick();
            w++;
        end
        check("send_ready_wait", 32'(u_if.ready_o), 32'd1);
        tick();
        u_if.valid_i = 1'b0;
    endtask

    // Entered on the first START cycle; bits[k] is the k-th bit on the line.
    task automatic run_frame(input string tag, input logic [15:0] bits, input int len,
                             input int div, input int cut_bit);
        int bad_tx;
        int bad_busy;
        int bad_rts;
        bad_tx = 0;
        bad_busy = 0;
        bad_rts = 0;
        for (int b = 0; b < len; b++) begin
            if (b == cut_bit) begin
                cts_n = 1'b1;
                tx_en = 1'b0;
            end
            for (int c = 0; c <= div; c++) begin
                if (tx !== bits[b]) bad_tx++;
                if (busy !== 1'b1) bad_busy++;
                if (rts_n !== 1'b0) bad_rts++;
                tick();
            end
        end
        check({tag, "_tx_bad_cycles"}, 32'(bad_tx), 32'd0);
        check({tag, "_busy_bad_cycles"}, 32'(bad_busy), 32'd0);
        check({tag, "_rts_bad_cycles"}, 32'(bad_rts), 32'd0);
    endtask

    // Accept, one IDLE cycle, one REQ cycle with grant present, then the frame and the IDLE after it.
    task automatic basic_frame(input string tag, input logic [7:0] d, input logic [15:0] bits,
                               input int len, input int div);
        send_byte(d);
        check({tag, "_ready_drop"}, 32'(u_if.ready_o), 32'd0);
        check({tag, "_rts_idle"}, 32'(rts_n), 32'd1);
        tick();
        check({tag, "_rts_req"}, 32'(rts_n), 32'd0);
        check({tag, "_busy_req"}, 32'(busy), 32'd0);
        tick();
        run_frame(tag, bits, len, div, -1);
        check({tag, "_rts_after"}, 32'(rts_n), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_tx_after"}, 32'(tx), 32'd1);
        check({tag, "_ready_after"}, 32'(u_if.ready_o), 32'd1);
    endtask

    initial begin
        int bad_a;
        int bad_b;
        int acc;
        logic exp_tx;
        logic exp_rts;
        logic [15:0] f1;
        logic [15:0] f2;

        rst = 1'b1;
        u_if.data_i = 8'h00;
        u_if.valid_i = 1'b0;
        baud_div = 16'd3;
        parity_en = 1'b0;
        parity_odd = 1'b0;
        stop2 = 1'b0;
        cts_n = 1'b0;
        tx_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rts", 32'(rts_n), 32'd1);
        check("reset_ready", 32'(u_if.ready_o), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        tick();

        // 8N1, 0xA5, 4 cycles per bit
        basic_frame("8n1_a5", 8'hA5, 16'h034A, 10, 3);

        // 0x03, parity, two stop bits, 1 cycle per bit: 12-cycle frames
        baud_div = 16'd0;
        parity_en = 1'b1;
        stop2 = 1'b1;
        parity_odd = 1'b0;
        basic_frame("par_even", 8'h03, 16'h0C06, 12, 0);
        parity_odd = 1'b1;
        basic_frame("par_odd", 8'h03, 16'h0E06, 12, 0);

        // Grant wait: CTS withheld, then CTS without enable, then enable
        baud_div = 16'd1;
        parity_en = 1'b0;
        stop2 = 1'b0;
        parity_odd = 1'b0;
        cts_n = 1'b1;
        send_byte(8'h3C);
        tick();
        bad_a = 0;
        for (int i = 0; i < 50; i++) begin
            if (rts_n !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad_a++;
            tick();
        end
        check("wait_cts_bad_cycles", 32'(bad_a), 32'd0);
        cts_n = 1'b0;
        tx_en = 1'b0;
        bad_a = 0;
        for (int i = 0; i < 10; i++) begin
            if (rts_n !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad_a++;
            tick();
        end
        check("wait_en_bad_cycles", 32'(bad_a), 32'd0);
        tx_en = 1'b1;
        tick();
        check("grant_start_tx", 32'(tx), 32'd0);
        run_frame("grant_3c", 16'h0278, 10, 1, -1);
        check("grant_rts_after", 32'(rts_n), 32'd1);

        // Back-to-back 0x55 then 0xAA, 3 cycles per bit
        baud_div = 16'd2;
        f1 = 16'h02AA;
        f2 = 16'h0354;
        send_byte(8'h55);
        u_if.data_i = 8'hAA;
        u_if.valid_i = 1'b1;
        acc = -1;
        bad_a = 0;
        bad_b = 0;
        for (int i = 0; i < 64; i++) begin
            if (i >= 2 && i <= 31) exp_tx = f1[(i - 2) / 3];
            else if (i >= 33 && i <= 62) exp_tx = f2[(i - 33) / 3];
            else exp_tx = 1'b1;
            exp_rts = (i >= 1 && i <= 62) ? 1'b0 : 1'b1;
            if (tx !== exp_tx) bad_a++;
            if (rts_n !== exp_rts) bad_b++;
            if (acc < 0 && u_if.valid_i === 1'b1 && u_if.ready_o === 1'b1) acc = i;
            tick();
            if (acc >= 0) u_if.valid_i = 1'b0;
        end
        u_if.valid_i = 1'b0;
        check("b2b_accept_cycle", 32'(acc), 32'd2);
        check("b2b_tx_bad_cycles", 32'(bad_a), 32'd0);
        check("b2b_rts_bad_cycles", 32'(bad_b), 32'd0);

        // CTS released and enable dropped at data bit 3: frame must complete unchanged
        baud_div = 16'd1;
        send_byte(8'h96);
        tick();
        tick();
        run_frame("cut_96", 16'h032C, 10, 1, 4);
        check("cut_rts_after", 32'(rts_n), 32'd1);
        check("cut_busy_after", 32'(busy), 32'd0);
        cts_n = 1'b0;
        tx_en = 1'b1;

        // Reset at data bit 3 aborts the frame
        baud_div = 16'd2;
        send_byte(8'h96);
        tick();
        tick();
        check("rst_frame_started", 32'(tx), 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("rst_bit3_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_rts", 32'(rts_n), 32'd1);
        check("rst_mid_ready", 32'(u_if.ready_o), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        bad_a = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || rts_n !== 1'b1 || busy !== 1'b0) bad_a++;
            tick();
        end
        check("rst_no_residual", 32'(bad_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
